// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
//   fetch_state_t : fetch FSM state encoding
//   INSTR_BYTES   : byte stride of one instruction (sequential PC step)
//   PC_W          : program counter / address width
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        HALTED,
        FAULT
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;
    localparam int PC_W        = 32;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Up-counter bounding how long a fetch may wait on instruction memory.
// Ports:
//   clk     : system clock
//   reset   : asynchronous active-low reset
//   clear   : synchronous clear to 0 (wins over enable)
//   enable  : count one more waiting cycle
//   expired : count has reached LIMIT-1
module fetch_timeout_counter #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == 8'(LIMIT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch controller: owns the PC, reads each instruction through
// an imem req/ready handshake, holds it for execute until acknowledged, and
// selects the next PC (sequential or branch). Handles run/halt and faults
// (misaligned branch target, memory timeout).
//
// Optional build macro FETCH_PERF_COUNTERS_EN adds retired_count and
// stall_count outputs.
//
// Ports:
//   clk, reset (async active-low)
//   run, halt_req                : run/halt control levels
//   imem_req/addr/rdata/ready    : instruction memory read handshake
//   instr, instr_valid, instr_ack: instruction presented to execute
//   branch_taken, branch_target  : next-PC selection, sampled with instr_ack
//   pc, halted, fault            : status
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | not running; waits for run
// FETCH  | imem_req high, waiting for imem_ready (bounded by timeout)
// EXEC   | instr_valid high, waiting for instr_ack
// HALTED | stopped after retire; resumes when halt_req=0 and run=1
// FAULT  | sticky error; only reset leaves
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC       = 32'h0000_0000,
    parameter int              TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            halt_req,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    output logic [31:0]     instr,
    output logic            instr_valid,
    input  logic            instr_ack,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            fault
`ifdef FETCH_PERF_COUNTERS_EN
   ,output logic [31:0]     retired_count,
    output logic [31:0]     stall_count
`endif
);

    fetch_state_t state, state_nx;
    logic         tmo_expired;
    logic         fetch_done;
    logic         retire;
    logic         misaligned;

    assign fetch_done = (state == FETCH) && imem_ready;
    assign misaligned = branch_taken && (branch_target[1:0] != 2'b00);
    // An acked instruction retires unless its branch target is misaligned.
    assign retire     = (state == EXEC) && instr_ack && !misaligned;

    fetch_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk     (clk),
        .reset   (reset),
        .clear   ((state != FETCH) || imem_ready),
        .enable  ((state == FETCH) && !imem_ready),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (run) state_nx = FETCH;
            end
            FETCH: begin
                if (imem_ready)       state_nx = EXEC;
                else if (tmo_expired) state_nx = FAULT;
            end
            EXEC: begin
                if (instr_ack) begin
                    if (misaligned)    state_nx = FAULT;
                    else if (halt_req) state_nx = HALTED;
                    else if (!run)     state_nx = IDLE;
                    else               state_nx = FETCH;
                end
            end
            HALTED: begin
                if (!halt_req && run) state_nx = FETCH;
            end
            FAULT:   state_nx = FAULT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc    <= RESET_PC;
            instr <= '0;
        end else begin
            if (fetch_done) instr <= imem_rdata;
            if (retire) pc <= branch_taken ? branch_target
                                           : pc + PC_W'(INSTR_BYTES);
        end
    end

    assign imem_req    = (state == FETCH);
    assign instr_valid = (state == EXEC);
    assign halted      = (state == HALTED);
    assign fault       = (state == FAULT);
    assign imem_addr   = pc;

`ifdef FETCH_PERF_COUNTERS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_count <= '0;
            stall_count   <= '0;
        end else begin
            if (retire) retired_count <= retired_count + 32'd1;
            if ((state == FETCH) && !imem_ready) stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        run, halt_req, imem_ready, instr_ack, branch_taken;
    logic [31:0] imem_rdata, branch_target;
    logic        imem_req, instr_valid, halted, fault;
    logic [31:0] imem_addr, instr, pc;

    logic        w_run;
    logic        w_req, w_valid, w_halted, w_fault;
    logic [31:0] w_addr, w_instr, w_pc;
    logic [31:0] w_rdata;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] retired_count, stall_count, w_retired, w_stall;
`endif

    int          nvec = 0;
    int          nerr = 0;
    int          exp_stall = 0;
    int          exp_ret = 0;
    logic [31:0] q[$];

    assign w_rdata = 32'h1357_9BDF;

    fetch_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(rst_n), .run(run), .halt_req(halt_req),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ready(imem_ready), .instr(instr), .instr_valid(instr_valid),
        .instr_ack(instr_ack), .branch_taken(branch_taken),
        .branch_target(branch_target), .pc(pc), .halted(halted), .fault(fault)
`ifdef FETCH_PERF_COUNTERS_EN
       ,.retired_count(retired_count), .stall_count(stall_count)
`endif
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT_CYCLES(16)) u_wrap (
        .clk(clk), .reset(rst_n), .run(w_run), .halt_req(1'b0),
        .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
        .imem_ready(1'b1), .instr(w_instr), .instr_valid(w_valid),
        .instr_ack(1'b1), .branch_taken(1'b0), .branch_target(32'h0),
        .pc(w_pc), .halted(w_halted), .fault(w_fault)
`ifdef FETCH_PERF_COUNTERS_EN
       ,.retired_count(w_retired), .stall_count(w_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; run = 1'b0; halt_req = 1'b0; imem_ready = 1'b0;
        instr_ack = 1'b0; branch_taken = 1'b0; branch_target = '0; w_run = 1'b0;
        exp_stall = 0; exp_ret = 0; q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge with the DUT in FETCH; returns at the EXEC negedge.
    task automatic do_fetch(input int waits, input logic [31:0] addr);
        logic [31:0] word;
        for (int w = 0; w <= waits; w++) begin
            chk("fetch_req", imem_req, 1);
            chk("fetch_addr", imem_addr, addr);
            chk("fetch_valid_low", instr_valid, 0);
            if (w < waits) begin
                imem_ready = 1'b0;
            end else begin
                word = $urandom;
                imem_rdata = word;
                imem_ready = 1'b1;
                q.push_back(word);
            end
            @(negedge clk);
        end
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        exp_stall += waits;
        chk("exec_valid", instr_valid, 1);
        chk("exec_req_low", imem_req, 0);
        chk("exec_fault_low", fault, 0);
        if (q.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL instr: got %h expected <nothing queued>", instr);
        end else begin
            chk("instr", instr, q.pop_front());
        end
`ifdef FETCH_PERF_COUNTERS_EN
        chk("stall_count", stall_count, exp_stall);
`endif
    endtask

    task automatic do_exec(input logic bt, input logic [31:0] tgt);
        instr_ack = 1'b1;
        branch_taken = bt;
        branch_target = tgt;
        if (!(bt && tgt[1:0] != 2'b00)) exp_ret++;
        @(negedge clk);
        instr_ack = 1'b0;
        branch_taken = 1'b0;
`ifdef FETCH_PERF_COUNTERS_EN
        chk("retired_count", retired_count, exp_ret);
`endif
    endtask

    typedef struct {
        int          waits;
        logic        bt;
        logic [31:0] tgt;
        logic [31:0] addr;
    } vec_t;

    vec_t tbl[9];
    int   cnt;

    initial begin
        tbl = '{
            '{0, 1'b0, 32'h0,  32'h00},
            '{0, 1'b0, 32'h0,  32'h04},
            '{0, 1'b0, 32'h0,  32'h08},
            '{0, 1'b0, 32'h0,  32'h0C},
            '{0, 1'b1, 32'h8,  32'h10},
            '{0, 1'b1, 32'h40, 32'h08},
            '{3, 1'b0, 32'h0,  32'h40},
            '{3, 1'b0, 32'h0,  32'h44},
            '{1, 1'b0, 32'h0,  32'h48}
        };

        rst_n = 1'b0; run = 1'b0; halt_req = 1'b0; imem_ready = 1'b0;
        imem_rdata = '0; instr_ack = 1'b0; branch_taken = 1'b0;
        branch_target = '0; w_run = 1'b0;
        @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fault", fault, 0);
        chk("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: boot sequence, wait states, aligned branches
        run = 1'b1;
        @(negedge clk);
        foreach (tbl[i]) begin
            do_fetch(tbl[i].waits, tbl[i].addr);
            chk("exec_pc", pc, tbl[i].addr);
            do_exec(tbl[i].bt, tbl[i].tgt);
        end
        chk("after_table_addr", imem_addr, 32'h4C);

        // Misaligned branch target at pc=8
        do_reset();
        run = 1'b1;
        @(negedge clk);
        do_fetch(0, 32'h0); do_exec(1'b0, 0);
        do_fetch(0, 32'h4); do_exec(1'b0, 0);
        do_fetch(0, 32'h8); do_exec(1'b1, 32'h42);
        for (int k = 0; k < 3; k++) begin
            chk("misalign_fault", fault, 1);
            chk("misalign_pc", pc, 32'h8);
            chk("misalign_req", imem_req, 0);
            @(negedge clk);
        end

        // Memory timeout
        do_reset();
        run = 1'b1;
        @(negedge clk);
        cnt = 0;
        while (!fault && cnt < 40) begin
            if (imem_req) cnt++;
            @(negedge clk);
        end
        chk("timeout_cycles", cnt, 16);
        chk("timeout_fault", fault, 1);
        chk("timeout_req", imem_req, 0);
`ifdef FETCH_PERF_COUNTERS_EN
        chk("timeout_stalls", stall_count, 16);
`endif

        // Asynchronous reset mid-fetch
        do_reset();
        run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("midfetch_req_before", imem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_req_drop", imem_req, 0);
        chk("async_pc", pc, 32'h0);
        chk("async_fault", fault, 0);
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_req", imem_req, 0);
        chk("idle_valid", instr_valid, 0);
        run = 1'b1;
        @(negedge clk);
        chk("idle_to_fetch", imem_req, 1);

        // Halt during fetch at pc=4, resume, then branch+halt together
        do_reset();
        run = 1'b1;
        @(negedge clk);
        do_fetch(0, 32'h0); do_exec(1'b0, 0);
        halt_req = 1'b1;
        do_fetch(1, 32'h4); do_exec(1'b0, 0);
        chk("halt_halted", halted, 1);
        chk("halt_pc", pc, 32'h8);
        chk("halt_req_low", imem_req, 0);
        @(negedge clk);
        chk("halt_stays", halted, 1);
        halt_req = 1'b0;
        @(negedge clk);
        chk("resume_halted", halted, 0);
        do_fetch(0, 32'h8);
        halt_req = 1'b1;
        do_exec(1'b1, 32'h100);
        chk("brhalt_halted", halted, 1);
        chk("brhalt_pc", pc, 32'h100);
        halt_req = 1'b0;

        // PC wrap from 0xFFFF_FFFC
        do_reset();
        w_run = 1'b1;
        @(negedge clk);
        chk("wrap_req1", w_req, 1);
        chk("wrap_addr1", w_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_valid", w_valid, 1);
        chk("wrap_instr", w_instr, 32'h1357_9BDF);
        @(negedge clk);
        chk("wrap_req2", w_req, 1);
        chk("wrap_addr2", w_addr, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Multi-cycle fetch controller for the 32-bit non-pipelined processor.
- Owns the PC and sequences each instruction-memory read through a req/ready handshake.
- Presents the fetched instruction to the execute/control logic and waits for its completion acknowledge.
- Applies the next-PC selection: sequential or branch. Also handles run/halt control and fault detection: misaligned branch target, memory timeout.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, maximum FETCH cycles waiting on imem_ready before FAULT; range 2..255.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- run  input  1  level; 1 = allow fetching.
- halt_req  input  1  level; request stop after the current instruction retires.
- imem_req  output  1  read request to instruction memory.
- imem_addr  output  32  read address; equals pc.
- imem_rdata  input  32  instruction word; valid when imem_ready=1.
- imem_ready  input  1  memory completes the read this cycle.
- instr  output  32  latched instruction.
- instr_valid  output  1  instr holds an un-retired instruction.
- instr_ack  input  1  execute logic retires instr this cycle.
- branch_taken  input  1  sampled with instr_ack.
- branch_target  input  32  sampled with instr_ack when branch_taken=1.
- pc  output  32  current program counter.
- halted  output  1  in HALTED state.
- fault  output  1  in FAULT state.

Behaviour:
- Reset (reset=0, asynchronous) forces the following values immediately; imem_req drops without waiting for a clock edge:
  - state=IDLE, pc=RESET_PC, instr=0.
  - instr_valid=0, imem_req=0, halted=0, fault=0, timeout counter=0.
- State machine is Moore. Outputs decode from registered state:
  - imem_req = (state==FETCH).
  - instr_valid = (state==EXEC).
  - halted = (state==HALTED).
  - fault = (state==FAULT).
  - imem_addr = pc at all times.
- IDLE: run=1 -> FETCH next edge; otherwise stay.
- FETCH:
  - On an edge with imem_ready=1: instr<=imem_rdata, counter<=0, go to EXEC.
  - imem_ready may be 1 in the same cycle FETCH is entered.
  - Otherwise counter increments. When counter reaches TIMEOUT_CYCLES-1 with imem_ready=0 -> FAULT.
  - halt_req and run=0 are ignored in FETCH; an in-flight fetch always completes.
- EXEC: wait for instr_ack=1. On the ack edge:
  - If branch_taken=1 and branch_target[1:0]!=0 -> FAULT, pc unchanged.
  - If branch_taken=1 and target aligned -> pc<=branch_target.
  - Otherwise pc<=pc+4, modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
  - Next state, in priority order: FAULT (misaligned), then HALTED if halt_req=1, else IDLE if run=0, else FETCH.
- HALTED: pc holds its next value. Exits to FETCH when halt_req=0 and run=1.
- FAULT: sticky. Only reset exits.
- instr_ack outside EXEC is ignored. A simultaneous branch and halt applies the branch PC, then halts.
- Minimum throughput: 2 cycles per instruction (FETCH 1 cycle, EXEC 1 cycle).
- branch_target[1:0] must be 0 by contract. Low bits are not truncated.

Optional Feature:
- Macro: FETCH_PERF_COUNTERS_EN.
- When defined, two extra outputs exist, both reset to 0 and wrapping at 2^32:
  - retired_count[31:0]: increments on every EXEC ack edge that does not fault.
  - stall_count[31:0]: increments on every FETCH cycle with imem_ready=0.
- When undefined, neither port nor its logic exists, and behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg holds:
  - typedef enum logic [2:0] fetch_state_t {IDLE, FETCH, EXEC, HALTED, FAULT}.
  - localparam INSTR_BYTES=4.
  - localparam PC_W=32.
- One sub-module, fetch_timeout_counter. It is an 8-bit counter with inputs clear and enable, and output expired at the limit value. It is instantiated once.
- The FSM, PC register and instruction register stay in fetch_sequencer.

Test Plan:
- Reset/boot: reset=0 then 1, run=1, imem_ready always 1, instr_ack every EXEC cycle.
  - Expect imem_addr sequence 0,4,8,12,16.
  - Expect instr_valid high every other cycle.
  - Expect instr equal to each returned word.
- Wait states: imem_ready delayed 3 cycles per fetch.
  - Expect imem_req held for 4 cycles and imem_addr stable during them.
  - Expect no fault.
  - With the macro: stall_count=3 per fetch.
- Branch: at pc=8, ack with branch_taken=1 and target 32'h40 -> next imem_addr=32'h40.
  - Target 32'h42 instead -> fault=1, pc stays 8, no further imem_req.
- Timeout: imem_ready held 0 -> fault asserts after exactly 16 FETCH cycles.
  - reset=0 mid-FETCH -> imem_req drops immediately.
  - Then pc=RESET_PC and state IDLE.
- Halt/resume: halt_req=1 during FETCH at pc=4.
  - Expect fetch completes, ack retires it, halted=1, pc=8.
  - Release halt_req -> FETCH at 8.
- Wrap: RESET_PC=32'hFFFF_FFFC -> second fetch address is 32'h0000_0000.
